// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the MMIO console write path and the UARTTX serializer, drained by a SEND/GAP/WAIT handshake FSM.
// Optional drop statistics (OVF, DROP_CNT) are built when UART_TX_FIFO_STAT_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic [7:0]            WDATA,
    input  logic                  WE,
    input  logic                  CLR,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic [7:0]            TX_DATA,
    output logic                  TX_WE,
    input  logic                  TX_READY,
    output logic                  OVF,
    output logic [15:0]           DROP_CNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } state_t;

    state_t                state, state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  push, pop;

    // CLR wins over a simultaneous push and also suppresses an IDLE pop.
    assign push = WE && !FULL && !CLR;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!EMPTY && TX_READY && !CLR) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: state_next = ST_GAP;
            ST_GAP:  state_next = ST_WAIT;   // UARTTX READY lags WE by a cycle; ignore it here
            ST_WAIT: if (TX_READY) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        level_next = LEVEL;
        if (CLR)
            level_next = '0;
        else if (push && !pop)
            level_next = LEVEL + 1'b1;
        else if (pop && !push)
            level_next = LEVEL - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            LEVEL   <= '0;
            FULL    <= 1'b0;
            EMPTY   <= 1'b1;
            TX_WE   <= 1'b0;
            TX_DATA <= 8'h00;
        end else begin
            state <= state_next;
            TX_WE <= pop;
            if (pop)
                TX_DATA <= mem[rd_ptr];
            LEVEL <= level_next;
            FULL  <= (level_next == FULL_LVL);
            EMPTY <= (level_next == '0);
            if (CLR) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; LEVEL gates every read, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= WDATA;
    end

`ifdef UART_TX_FIFO_STAT_EN
    logic drop;

    assign drop = WE && FULL && !CLR;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            OVF      <= 1'b0;
            DROP_CNT <= 16'h0000;
        end else if (CLR) begin
            OVF      <= 1'b0;
            DROP_CNT <= 16'h0000;
        end else if (drop) begin
            OVF <= 1'b1;
            if (DROP_CNT != 16'hFFFF)
                DROP_CNT <= DROP_CNT + 16'h0001;
        end
    end
`else
    assign OVF      = 1'b0;
    assign DROP_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every cycle plus directed literal checks.
// Statistics expectations follow UART_TX_FIFO_STAT_EN when it is defined for the build.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic [7:0]    WDATA = 8'h00;
    logic          WE = 1'b0;
    logic          CLR = 1'b0;
    logic          FULL, EMPTY;
    logic [DL:0]   LEVEL;
    logic [7:0]    TX_DATA;
    logic          TX_WE;
    logic          TX_READY;
    logic          OVF;
    logic [15:0]   DROP_CNT;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .CLK(CLK), .RST_X(RST_X), .WDATA(WDATA), .WE(WE), .CLR(CLR),
        .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .TX_DATA(TX_DATA),
        .TX_WE(TX_WE), .TX_READY(TX_READY), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // UARTTX stand-in: READY low for 10 cycles after each WE pulse; manual override for directed tests.
    logic man_ready  = 1'b1;
    logic auto_ready = 1'b0;
    logic uart_ready = 1'b1;
    int   uart_cnt   = 0;

    assign TX_READY = auto_ready ? uart_ready : man_ready;

    always @(negedge CLK) begin
        if (TX_WE)
            uart_cnt = 10;
        else if (uart_cnt > 0)
            uart_cnt--;
        uart_ready = (uart_cnt == 0);
    end

    // Reference model: byte queue plus a "serializer busy" window measured in edges since the last pop.
    logic [7:0]  mq[$];
    bit          m_busy = 0;
    int          m_edges = 0;
    bit          m_we = 0;
    logic [7:0]  m_data = 8'h00;
    bit          m_ovf = 0;
    logic [15:0] m_drop = 16'h0000;
    bit          m_full, m_pop, m_push, m_dropped;

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mq.delete();
            m_busy  = 0;
            m_edges = 0;
            m_we    = 0;
            m_data  = 8'h00;
            m_ovf   = 0;
            m_drop  = 16'h0000;
        end else begin
            m_full    = (mq.size() == DEPTH);
            m_pop     = !m_busy && (mq.size() != 0) && TX_READY && !CLR;
            m_push    = WE && !m_full && !CLR;
            m_dropped = WE && m_full && !CLR;
            m_we      = m_pop;
            if (m_pop) begin
                m_data  = mq[0];
                m_busy  = 1;
                m_edges = 0;
            end else if (m_busy) begin
                m_edges++;
                if (m_edges >= 3 && TX_READY)
                    m_busy = 0;
            end
            if (CLR) begin
                mq.delete();
            end else begin
                if (m_pop)
                    void'(mq.pop_front());
                if (m_push)
                    mq.push_back(WDATA);
            end
`ifdef UART_TX_FIFO_STAT_EN
            if (CLR) begin
                m_ovf  = 0;
                m_drop = 16'h0000;
            end else if (m_dropped) begin
                m_ovf = 1;
                if (m_drop != 16'hFFFF)
                    m_drop = m_drop + 16'h0001;
            end
`endif
        end
    end

    // Every-cycle compare against the model; also logs each byte handed to UARTTX.
    logic [7:0] sent[$];
    bit         prev_we = 0;

    always @(negedge CLK) begin
        check("level", 32'(LEVEL), 32'(mq.size()));
        check("full", 32'(FULL), 32'(mq.size() == DEPTH));
        check("empty", 32'(EMPTY), 32'(mq.size() == 0));
        check("tx_we", 32'(TX_WE), 32'(m_we));
        check("tx_data", 32'(TX_DATA), 32'(m_data));
        check("ovf", 32'(OVF), 32'(m_ovf));
        check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
        check("tx_we_back_to_back", 32'(TX_WE && prev_we), 32'd0);
        prev_we = TX_WE;
        if (TX_WE)
            sent.push_back(TX_DATA);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_byte(input logic [7:0] b);
        WE    = 1'b1;
        WDATA = b;
        @(negedge CLK);
        WE    = 1'b0;
    endtask

    task automatic wait_empty(input int limit, input string name);
        int n = 0;
        while (!EMPTY && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(EMPTY), 32'd1);
    endtask

    task automatic wait_tx_we(input int limit, input string name);
        int n = 0;
        while (!TX_WE && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(TX_WE), 32'd1);
    endtask

    int         start;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    initial begin
        // Reset state
        cyc(2);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_tx_we", 32'(TX_WE), 32'd0);
        check("rst_tx_data", 32'(TX_DATA), 32'h00);
        RST_X = 1'b1;
        cyc(3);

        // 1: single-byte latency
        WE = 1'b1; WDATA = 8'h41;
        @(negedge CLK); WE = 1'b0;
        check("t1_level_n1", 32'(LEVEL), 32'd1);
        @(negedge CLK);
        check("t1_tx_we_n2", 32'(TX_WE), 32'd1);
        check("t1_tx_data_n2", 32'(TX_DATA), 32'h41);
        @(negedge CLK);
        check("t1_level_n3", 32'(LEVEL), 32'd0);
        check("t1_empty_n3", 32'(EMPTY), 32'd1);
        check("t1_tx_we_n3", 32'(TX_WE), 32'd0);
        cyc(5);

        // 2: fill with READY low, 17th push dropped
        man_ready = 1'b0;
        cyc(1);
        for (int i = 0; i < 16; i++)
            push_byte(8'(i));
        check("t2_full", 32'(FULL), 32'd1);
        check("t2_level", 32'(LEVEL), 32'd16);
        push_byte(8'hAA);
        check("t2_level_after_drop", 32'(LEVEL), 32'd16);
`ifdef UART_TX_FIFO_STAT_EN
        check("t2_ovf", 32'(OVF), 32'd1);
        check("t2_drop_cnt", 32'(DROP_CNT), 32'd1);
`endif

        // 3: READY rises together with a push while full: pop wins, push dropped
        start = sent.size();
        WE = 1'b1; WDATA = 8'hBB; man_ready = 1'b1;
        @(negedge CLK); WE = 1'b0;
        check("t3_level", 32'(LEVEL), 32'd15);
        check("t3_full", 32'(FULL), 32'd0);
        check("t3_tx_we", 32'(TX_WE), 32'd1);
        check("t3_tx_data", 32'(TX_DATA), 32'h00);
`ifdef UART_TX_FIFO_STAT_EN
        check("t3_drop_cnt", 32'(DROP_CNT), 32'd2);
`endif
        auto_ready = 1'b1;
        wait_empty(2000, "t2_drain_timeout");
        cyc(20);
        check("t2_sent_count", 32'(sent.size() - start), 32'd16);
        for (int i = 0; i < 16 && start + i < sent.size(); i++)
            check("t2_order", 32'(sent[start+i]), 32'(i));

        // 4: CLR with simultaneous WE while byte 0 sits in WAIT
        start = sent.size();
        for (int i = 0; i < 5; i++)
            push_byte(8'(8'h50 + i));
        check("t4_level_before_clr", 32'(LEVEL), 32'd4);
        check("t4_byte0_sent", 32'(sent.size() - start), 32'd1);
        CLR = 1'b1; WE = 1'b1; WDATA = 8'hEE;
        @(negedge CLK);
        CLR = 1'b0; WE = 1'b0;
        check("t4_level", 32'(LEVEL), 32'd0);
        check("t4_empty", 32'(EMPTY), 32'd1);
        check("t4_ovf", 32'(OVF), 32'd0);
        check("t4_drop_cnt", 32'(DROP_CNT), 32'd0);
        cyc(40);
        check("t4_sent_count", 32'(sent.size() - start), 32'd1);
        if (sent.size() > start)
            check("t4_byte0", 32'(sent[start]), 32'h50);

        // 5: async reset during SEND
        push_byte(8'h61);
        push_byte(8'h62);
        check("t5_send_we", 32'(TX_WE), 32'd1);
        check("t5_send_data", 32'(TX_DATA), 32'h61);
        check("t5_level_pre", 32'(LEVEL), 32'd1);
        #1 RST_X = 1'b0;
        #1;
        check("t5_rst_tx_we", 32'(TX_WE), 32'd0);
        check("t5_rst_tx_data", 32'(TX_DATA), 32'h00);
        check("t5_rst_level", 32'(LEVEL), 32'd0);
        check("t5_rst_empty", 32'(EMPTY), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
        push_byte(8'h63);
        wait_tx_we(40, "t5_restart_timeout");
        check("t5_restart_data", 32'(TX_DATA), 32'h63);
        cyc(20);

        // 6: random stream with wrap-around
        start = sent.size();
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            cyc($urandom_range(0, 3));
            while (FULL && n < 200) begin
                @(negedge CLK);
                n++;
            end
            b = 8'($urandom);
            exp_q.push_back(b);
            push_byte(b);
        end
        wait_empty(2000, "t6_drain_timeout");
        cyc(20);
        check("t6_sent_count", 32'(sent.size() - start), 32'd40);
        for (int i = 0; i < 40 && start + i < sent.size(); i++)
            check("t6_order", 32'(sent[start+i]), 32'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the MMIO `MMIO_TO_HOST` write path and the UARTTX serializer.
- Absorbs bursts of console writes so the CPU does not spin on `tx_ready` per byte.
- MMIO reads of `MMIO_TO_HOST` return `~FULL` instead of the raw UARTTX `READY`.
- Drains automatically into UARTTX using its `DATA`/`WE`/`READY` handshake, one byte per serial frame.

Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2**DEPTH_LOG2 bytes (16 by default).

Ports:
- `CLK` in 1: single clock, CPU clock domain.
- `RST_X` in 1: asynchronous active-low reset.
- `WDATA` in 8: byte from the MMIO write.
- `WE` in 1: push strobe, one cycle per byte.
- `CLR` in 1: synchronous flush of queued bytes.
- `FULL` out 1: FIFO holds 2**DEPTH_LOG2 bytes.
- `EMPTY` out 1: FIFO holds 0 bytes.
- `LEVEL` out DEPTH_LOG2+1: current occupancy.
- `TX_DATA` out 8: byte to UARTTX `DATA`.
- `TX_WE` out 1: one-cycle pulse to UARTTX `WE`.
- `TX_READY` in 1: UARTTX `READY`, high when the serializer is idle.
- `OVF` out 1: sticky overflow flag (optional feature only).
- `DROP_CNT` out 16: count of dropped pushes (optional feature only).

Behaviour:
- **Reset.** `RST_X` low asynchronously sets:
  - pointers = 0, `LEVEL` = 0, `EMPTY` = 1, `FULL` = 0;
  - `TX_WE` = 0, `TX_DATA` = 0x00, FSM = IDLE, `OVF` = 0, `DROP_CNT` = 0.
  - Reset mid-transfer drops `TX_WE` immediately and discards all queued bytes.
- **Storage.** 2**DEPTH_LOG2 x 8 register array.
  - Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - `LEVEL` is a separate DEPTH_LOG2+1 bit counter.
- **Status outputs.** All registered and derived from `LEVEL`; they update on the edge after the push or pop.
- **Push.**
  - `WE` high, `FULL` low and `CLR` low: write `WDATA` at the write pointer, increment the pointer, `LEVEL` +1.
  - `WE` while `FULL` is high: the byte is dropped, even if a pop occurs in the same cycle. No state change except the optional stats.
- **Simultaneous push and pop** (not full): `LEVEL` is unchanged and both pointers advance.
- **Drain FSM states:**
  - IDLE: if `!EMPTY` and `TX_READY`, then on the edge set `TX_DATA` <= mem[rd], `TX_WE` <= 1, rd +1, `LEVEL` -1, go to SEND.
  - SEND: `TX_WE` is high for exactly this cycle. Next edge: `TX_WE` <= 0, go to GAP.
  - GAP: one cycle during which `TX_READY` is ignored, covering UARTTX's registered `READY` deassert. Go to WAIT.
  - WAIT: stay until `TX_READY` = 1, then go to IDLE.
  - `TX_DATA` holds its value after SEND until the next SEND.
- **Latency.** Push into an empty FIFO with FSM in IDLE and `TX_READY` = 1 at cycle N gives:
  - `LEVEL` = 1 at N+1;
  - `TX_WE` high during N+2 with `TX_DATA` = the pushed byte;
  - `LEVEL` = 0 at N+3.
- **Throughput.** Back-to-back bytes: the next `TX_WE` fires 1 cycle after WAIT observes `TX_READY`.
- **`CLR`.**
  - Zeroes both pointers and `LEVEL`; `CLR` wins over a simultaneous `WE`, which is dropped and not counted.
  - Does not abort the FSM: a byte already in SEND/GAP/WAIT completes to UARTTX.
  - An IDLE pop in the same cycle as `CLR` is suppressed.
- **Width rules.**
  - `LEVEL` never exceeds 2**DEPTH_LOG2 and never underflows; a pop requires `!EMPTY`.
  - `TX_WE` is never high for two consecutive cycles.

Optional Feature:
- Macro: `UART_TX_FIFO_STAT_EN`.
- **Defined:**
  - Every push dropped because `FULL` is high sets `OVF`, which stays set until `CLR` or reset.
  - Each such drop increments `DROP_CNT`; `DROP_CNT` saturates at 0xFFFF and is cleared by `CLR` or reset.
  - Drops caused by `CLR` winning are not counted.
- **Undefined:** `OVF` and `DROP_CNT` are tied to 0 and no counter logic is synthesized. Ports exist in both builds.

Test Plan:
1. Reset, `TX_READY`=1, push 0x41 at cycle N: `LEVEL`=1 at N+1, `TX_WE` pulse at N+2 with `TX_DATA`=0x41, `LEVEL`=0 and `EMPTY`=1 at N+3.
2. Hold `TX_READY`=0 and push 16 bytes 0x00..0x0F: `FULL`=1, `LEVEL`=16. A 17th push of 0xAA is dropped; with the macro, `OVF`=1 and `DROP_CNT`=1. Release `TX_READY` with a UARTTX model: output order is 0x00..0x0F, 0xAA never appears.
3. At `LEVEL`=16, FSM in IDLE, raise `TX_READY` in the same cycle as a push: pop occurs, push is dropped, `LEVEL`=15.
4. Queue 5 bytes, assert `CLR` while the FSM is in WAIT for byte 0 with a simultaneous `WE`: byte 0 completes. `LEVEL`=0 the next cycle, no further `TX_WE`, `OVF`/`DROP_CNT` cleared.
5. Pulse `RST_X` low asynchronously during SEND: `TX_WE` drops before the next `CLK` edge, all outputs return to reset values, and the FIFO restarts cleanly with the next push.
6. Stream 40 random bytes with random `WE` gaps and a UARTTX `READY` model (low 10 cycles after each `WE`): pointer wrap-around is exercised, byte order is preserved, and `TX_WE` is never high on consecutive cycles.
